// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP TX frame builder: FSM state encoding,
// protocol header sizes and the UDP/IP length computation.
package udp_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_SEND   = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   localparam int UDP_HDR_BYTES = 8;
   localparam int IP_HDR_BYTES  = 20;

   // Header bytes plus payload bytes, truncated to a 16-bit length field.
   function automatic logic [15:0] frame_len(input logic [15:0] hdr_bytes,
                                             input logic [15:0] words,
                                             input logic [15:0] bytes_per_word);
      return hdr_bytes + 16'(words * bytes_per_word);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr_i+1 (mod
// NUM_CH) and returns it one-hot and as an index.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   gnt_idx_o,
   output logic              valid_o
);

   int j;

   // Scan the request vector starting just past the last winner.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      j         = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         j = (int'(ptr_i) + i) % NUM_CH;
         if (!valid_o && req_i[CH_W'(j)]) begin
            gnt_o[CH_W'(j)] = 1'b1;
            gnt_idx_o       = CH_W'(j);
            valid_o         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_tx_frame_builder.sv
// Multi-channel UDP TX frame builder. Latches per-channel send requests,
// arbitrates round-robin, streams the winner's payload from the shared source
// port into the TX RAM, then pulses a send request and waits for tx done.
// Optional feature: define TX_BUILDER_SEQ_EN to prepend a header word
// {channel, 8'h00, seq} at RAM address 0 with a per-send sequence counter.
//
// Source handshake: o_src_rd_en is a one-cycle strobe for (o_src_ch,
// o_src_idx); i_src_data must carry that word exactly one cycle later, with
// no backpressure in either direction.
module udp_tx_frame_builder
   import udp_tx_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 9,
   parameter int NUM_CH       = 4,
   parameter int MAX_WORDS    = 16,
   parameter int DONE_TIMEOUT = 4096,
   parameter int CNT_W        = $clog2(MAX_WORDS + 1),
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    i_sys_clk,
   input  logic                    i_rst,
   input  logic [NUM_CH-1:0]       i_req_start,
   input  logic [NUM_CH*CNT_W-1:0] i_req_word_cnt,
   output logic                    o_src_rd_en,
   output logic [CH_W-1:0]         o_src_ch,
   output logic [CNT_W-1:0]        o_src_idx,
   input  logic [DATA_W-1:0]       i_src_data,
   output logic                    o_pkg_ram_wr_en,
   output logic [ADDR_W-1:0]       o_pkg_ram_wr_addr,
   output logic [DATA_W-1:0]       o_pkg_ram_wr_data,
   output logic [15:0]             o_pkg_data_length,
   output logic [15:0]             o_pkg_data_total_length,
   output logic                    o_pkg_send_udp_req,
   input  logic                    i_tx_done,
   output logic                    o_busy,
   output logic                    o_err_timeout,
   output logic [1:0]              o_dbg_state
);

   localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);
`ifdef TX_BUILDER_SEQ_EN
   localparam int HDR_WORDS = 1;
`else
   localparam int HDR_WORDS = 0;
`endif

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]    cnt_q [NUM_CH];
   logic [CNT_W-1:0]    cnt_d [NUM_CH];
   logic [CNT_W-1:0]    raw_cnt;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d, cur_ch_q, cur_ch_d;
   logic [CNT_W-1:0]    n_q, n_d, idx_q, idx_d;
   logic [15:0]         len_q, len_d, tot_q, tot_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                rd_en, send_req, err_timeout;
   logic [NUM_CH-1:0]   gnt_onehot;
   logic [CH_W-1:0]     gnt_idx;
   logic                gnt_valid, grant_fire;
`ifdef TX_BUILDER_SEQ_EN
   logic                hdr_q, hdr_d, wr_hdr_q, wr_hdr_d;
   logic [15:0]         seq_q, seq_d;
`endif

   rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .req_i     (pending_q),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt_onehot),
      .gnt_idx_o (gnt_idx),
      .valid_o   (gnt_valid)
   );

   assign grant_fire = (state_q == S_IDLE) && gnt_valid;

   // Pending bitmap and clamped counts; a new start always wins over the grant clear.
   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      raw_cnt   = '0;
      if (grant_fire) pending_d = pending_q & ~gnt_onehot;
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_req_start[c]) begin
            raw_cnt      = i_req_word_cnt[c*CNT_W +: CNT_W];
            pending_d[c] = 1'b1;
            cnt_d[c]     = (raw_cnt > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : raw_cnt;
         end
      end
   end

   // Frame FSM: grant, stream reads (write lags by one cycle), send, wait for done.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cur_ch_d    = cur_ch_q;
      n_d         = n_q;
      idx_d       = idx_q;
      len_d       = len_q;
      tot_d       = tot_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      tmo_d       = tmo_q;
      rd_en       = 1'b0;
      send_req    = 1'b0;
      err_timeout = 1'b0;
`ifdef TX_BUILDER_SEQ_EN
      hdr_d       = hdr_q;
      wr_hdr_d    = 1'b0;
      seq_d       = seq_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               state_d  = S_STREAM;
               rr_ptr_d = gnt_idx;
               cur_ch_d = gnt_idx;
               n_d      = cnt_q[gnt_idx];
               idx_d    = '0;
               len_d    = frame_len(16'(UDP_HDR_BYTES),
                                    16'(cnt_q[gnt_idx]) + 16'(HDR_WORDS), 16'(DATA_W / 8));
               tot_d    = frame_len(16'(UDP_HDR_BYTES + IP_HDR_BYTES),
                                    16'(cnt_q[gnt_idx]) + 16'(HDR_WORDS), 16'(DATA_W / 8));
`ifdef TX_BUILDER_SEQ_EN
               hdr_d    = 1'b1;
`endif
            end
         end
         S_STREAM: begin
`ifdef TX_BUILDER_SEQ_EN
            if (hdr_q) begin
               hdr_d     = 1'b0;
               wr_en_d   = 1'b1;
               wr_hdr_d  = 1'b1;
               wr_addr_d = '0;
            end else
`endif
            if (idx_q != n_q) begin
               rd_en     = 1'b1;
               idx_d     = idx_q + 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'(idx_q) + ADDR_W'(HDR_WORDS);
            end else begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            send_req = 1'b1;
            tmo_d    = '0;
            state_d  = S_WAIT;
`ifdef TX_BUILDER_SEQ_EN
            seq_d    = seq_q + 16'd1;
`endif
         end
         S_WAIT: begin
            if (i_tx_done) begin
               state_d = S_IDLE;
            end else if (tmo_q == TMO_W'(DONE_TIMEOUT - 1)) begin
               err_timeout = 1'b1;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
         rr_ptr_q  <= CH_W'(NUM_CH - 1);
         cur_ch_q  <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         tot_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         tmo_q     <= '0;
`ifdef TX_BUILDER_SEQ_EN
         hdr_q     <= 1'b0;
         wr_hdr_q  <= 1'b0;
         seq_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         cur_ch_q  <= cur_ch_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         tot_q     <= tot_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         tmo_q     <= tmo_d;
`ifdef TX_BUILDER_SEQ_EN
         hdr_q     <= hdr_d;
         wr_hdr_q  <= wr_hdr_d;
         seq_q     <= seq_d;
`endif
      end
   end

   assign o_src_rd_en             = rd_en;
   assign o_src_ch                = rd_en ? cur_ch_q : '0;
   assign o_src_idx               = rd_en ? idx_q : '0;
   assign o_pkg_ram_wr_en         = wr_en_q;
   assign o_pkg_ram_wr_addr       = wr_addr_q;
`ifdef TX_BUILDER_SEQ_EN
   assign o_pkg_ram_wr_data       = !wr_en_q ? '0 :
                                    (wr_hdr_q ? DATA_W'({8'(cur_ch_q), 8'h00, seq_q}) : i_src_data);
`else
   assign o_pkg_ram_wr_data       = wr_en_q ? i_src_data : '0;
`endif
   assign o_pkg_data_length       = len_q;
   assign o_pkg_data_total_length = tot_q;
   assign o_pkg_send_udp_req      = send_req;
   assign o_busy                  = (state_q != S_IDLE);
   assign o_err_timeout           = err_timeout;
   assign o_dbg_state             = state_q;

endmodule

// File: tb/tb_udp_tx_frame_builder.sv
// Directed bench for udp_tx_frame_builder: a frame-level model predicts every
// RAM write and every send's lengths; a negedge compare process checks them.
module tb_udp_tx_frame_builder;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int NUM_CH = 4;
   localparam int MAX_WORDS = 16;
   localparam int DONE_TIMEOUT = 4096;
   localparam int CNT_W = 5;
   localparam int CH_W = 2;
`ifdef TX_BUILDER_SEQ_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_CH-1:0]       i_req_start = '0;
   logic [NUM_CH*CNT_W-1:0] i_req_word_cnt = '0;
   logic [DATA_W-1:0]       i_src_data = '0;
   logic                    i_tx_done = 1'b0;
   logic                    o_src_rd_en;
   logic [CH_W-1:0]         o_src_ch;
   logic [CNT_W-1:0]        o_src_idx;
   logic                    o_pkg_ram_wr_en;
   logic [ADDR_W-1:0]       o_pkg_ram_wr_addr;
   logic [DATA_W-1:0]       o_pkg_ram_wr_data;
   logic [15:0]             o_pkg_data_length;
   logic [15:0]             o_pkg_data_total_length;
   logic                    o_pkg_send_udp_req;
   logic                    o_busy;
   logic                    o_err_timeout;
   logic [1:0]              o_dbg_state;

   udp_tx_frame_builder #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
      .MAX_WORDS(MAX_WORDS), .DONE_TIMEOUT(DONE_TIMEOUT)
   ) dut (
      .i_sys_clk               (clk),
      .i_rst                   (rst),
      .i_req_start             (i_req_start),
      .i_req_word_cnt          (i_req_word_cnt),
      .o_src_rd_en             (o_src_rd_en),
      .o_src_ch                (o_src_ch),
      .o_src_idx               (o_src_idx),
      .i_src_data              (i_src_data),
      .o_pkg_ram_wr_en         (o_pkg_ram_wr_en),
      .o_pkg_ram_wr_addr       (o_pkg_ram_wr_addr),
      .o_pkg_ram_wr_data       (o_pkg_ram_wr_data),
      .o_pkg_data_length       (o_pkg_data_length),
      .o_pkg_data_total_length (o_pkg_data_total_length),
      .o_pkg_send_udp_req      (o_pkg_send_udp_req),
      .i_tx_done               (i_tx_done),
      .o_busy                  (o_busy),
      .o_err_timeout           (o_err_timeout),
      .o_dbg_state             (o_dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Source memory model: word content encodes channel and index
   function automatic logic [31:0] src_word(input logic [1:0] ch, input logic [4:0] idx);
      return {6'b110000, ch, 8'h5A, 11'h000, idx};
   endfunction

   logic             sr_rd = 1'b0;
   logic [CH_W-1:0]  sr_ch = '0;
   logic [CNT_W-1:0] sr_idx = '0;
   always @(negedge clk) begin
      sr_rd  = o_src_rd_en;
      sr_ch  = o_src_ch;
      sr_idx = o_src_idx;
   end
   always @(posedge clk) begin
      #1;
      i_src_data = sr_rd ? src_word(sr_ch, sr_idx) : 32'hDEAD_BEEF;
   end

   // Frame-level model: expected RAM writes and lengths per send
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [31:0]              exp_len_q[$];
   logic [15:0]              seq_exp = '0;
   int                       exp_err = 0;
   int                       n_send = 0;
   int                       n_err = 0;

   function automatic void push_frame(input int ch, input int n);
      int nc = (n > MAX_WORDS) ? MAX_WORDS : n;
      int pb;
`ifdef TX_BUILDER_SEQ_EN
      exp_q.push_back({ADDR_W'(0), 8'(ch), 8'h00, seq_exp});
      seq_exp = seq_exp + 16'd1;
`endif
      for (int k = 0; k < nc; k++)
         exp_q.push_back({ADDR_W'(k + HDR), src_word(2'(ch), 5'(k))});
      pb = (DATA_W / 8) * (nc + HDR);
      exp_len_q.push_back({16'(8 + pb), 16'(28 + pb)});
   endfunction

   // Compare process
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_len_q.delete();
      end else begin
         if (o_pkg_ram_wr_en) begin
            if (exp_q.size() == 0) check("unexpected_write", 64'(o_pkg_ram_wr_en), 64'd0);
            else check("ram_write", 64'({o_pkg_ram_wr_addr, o_pkg_ram_wr_data}), 64'(exp_q.pop_front()));
         end
         if (o_pkg_send_udp_req) begin
            n_send++;
            if (exp_len_q.size() == 0) check("unexpected_send", 64'(o_pkg_send_udp_req), 64'd0);
            else check("lengths", 64'({o_pkg_data_length, o_pkg_data_total_length}), 64'(exp_len_q.pop_front()));
         end
         if (o_err_timeout) begin
            n_err++;
            check("unexpected_err", 64'(o_err_timeout), 64'(exp_err > 0));
            if (exp_err > 0) exp_err--;
         end
      end
   end

   // Driver tasks
   task automatic start_chs(input logic [NUM_CH-1:0] mask, input int n, output int t);
      @(posedge clk); #1;
      i_req_start = mask;
      for (int c = 0; c < NUM_CH; c++)
         if (mask[c]) i_req_word_cnt[c*CNT_W +: CNT_W] = CNT_W'(n);
      t = cyc + 1;
      @(posedge clk); #1;
      i_req_start = '0;
   endtask

   task automatic wait_send(input string name, output int at);
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_pkg_send_udp_req) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check({name, "_no_send"}, 64'(o_pkg_send_udp_req), 64'd1);
   endtask

   task automatic give_done();
      @(posedge clk); #1;
      i_tx_done = 1'b1;
      @(posedge clk); #1;
      i_tx_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Directed test sequence
   initial begin
      int t, sc, ec, s0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_wr_en", 64'(o_pkg_ram_wr_en), 64'd0);
      check("rst_wr_addr", 64'(o_pkg_ram_wr_addr), 64'd0);
      check("rst_wr_data", 64'(o_pkg_ram_wr_data), 64'd0);
      check("rst_rd_en", 64'(o_src_rd_en), 64'd0);
      check("rst_src_idx", 64'(o_src_idx), 64'd0);
      check("rst_send", 64'(o_pkg_send_udp_req), 64'd0);
      check("rst_err", 64'(o_err_timeout), 64'd0);
      check("rst_len", 64'(o_pkg_data_length), 64'd0);
      check("rst_tot", 64'(o_pkg_data_total_length), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 64'(o_busy), 64'd0);

      // Ch0, n=5: latency and literal lengths
      push_frame(0, 5);
      start_chs(4'b0001, 5, t);
      repeat (2 + HDR) @(negedge clk);
      check("first_rd_en", 64'(o_src_rd_en), 64'd1);
      check("first_rd_idx", 64'(o_src_idx), 64'd0);
      check("first_rd_ch", 64'(o_src_ch), 64'd0);
      wait_send("ch0_n5", sc);
      check("send_latency", 64'(sc - t), 64'(7 + HDR));
      check("len_lit_n5", 64'(o_pkg_data_length), 64'(28 + 4 * HDR));
      check("tot_lit_n5", 64'(o_pkg_data_total_length), 64'(48 + 4 * HDR));
      give_done();
      @(negedge clk);
      check("busy_after_done", 64'(o_busy), 64'd0);

      // Ch1 and ch3 together, then ch0 and ch2 together (ch0 wins after ch3)
      push_frame(1, 2);
      push_frame(3, 2);
      start_chs(4'b1010, 2, t);
      wait_send("ch1", sc);
      give_done();
      wait_send("ch3", sc);
      push_frame(0, 1);
      push_frame(2, 1);
      start_chs(4'b0101, 1, t);
      give_done();
      wait_send("ch0_rr", sc);
      give_done();
      wait_send("ch2_rr", sc);
      give_done();

      // n=0: no writes, header-only lengths
      push_frame(2, 0);
      start_chs(4'b0100, 0, t);
      wait_send("ch2_n0", sc);
      check("send_latency_n0", 64'(sc - t), 64'(2 + HDR));
      check("len_lit_n0", 64'(o_pkg_data_length), 64'(8 + 4 * HDR));
      check("tot_lit_n0", 64'(o_pkg_data_total_length), 64'(28 + 4 * HDR));
      give_done();

      // n=20 clamped to 16; a stray tx_done during streaming is ignored
      push_frame(1, 20);
      start_chs(4'b0010, 20, t);
      i_tx_done = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      i_tx_done = 1'b0;
      wait_send("ch1_n20", sc);
      check("len_lit_n20", 64'(o_pkg_data_length), 64'(72 + 4 * HDR));
      check("tot_lit_n20", 64'(o_pkg_data_total_length), 64'(92 + 4 * HDR));
      give_done();

      // Done withheld: timeout pulse, then the pending channel is served
      push_frame(0, 1);
      start_chs(4'b0001, 1, t);
      wait_send("ch0_tmo", sc);
      exp_err = 1;
      push_frame(1, 1);
      start_chs(4'b0010, 1, t);
      ec = -1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (o_err_timeout) begin
            ec = cyc;
            break;
         end
      end
      check("timeout_latency", 64'(ec - sc), 64'd4096);
      @(negedge clk);
      check("err_one_cycle", 64'(o_err_timeout), 64'd0);
      wait_send("ch1_after_tmo", sc);
      give_done();
      check("err_count", 64'(n_err), 64'd1);

      // Reset mid-stream: everything idles, no send follows
      push_frame(2, 8);
      start_chs(4'b0100, 8, t);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 64'(o_busy), 64'd0);
      check("midrst_wr_en", 64'(o_pkg_ram_wr_en), 64'd0);
      check("midrst_rd_en", 64'(o_src_rd_en), 64'd0);
      check("midrst_len", 64'(o_pkg_data_length), 64'd0);
      s0 = n_send;
      @(posedge clk); #1;
      rst = 1'b0;
      seq_exp = '0;
      repeat (30) @(negedge clk);
      check("no_send_after_reset", 64'(n_send), 64'(s0));

      // After reset channel 0 wins first again
      push_frame(0, 1);
      push_frame(1, 1);
      start_chs(4'b0011, 1, t);
      wait_send("post_rst_ch0", sc);
      give_done();
      wait_send("post_rst_ch1", sc);
      give_done();
      repeat (3) @(negedge clk);

      check("writes_drained", 64'(exp_q.size()), 64'd0);
      check("sends_drained", 64'(exp_len_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
